cxapbasyncbridge_apb_arbiter: RTL

//  Round-robin arbiter that shares one APB3 master bus between NUM_REQ APB3 requesters
//  in the pclkm domain. Typical requesters are several async-bridge master domains.

---
 rtl/cxapbasyncbridge_apb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cxapbasyncbridge_apb_arbiter.sv
// Round-robin arbiter sharing one APB3 master bus between NUM_REQ APB3 requesters.
// One transfer is in flight at a time; requesters that are not granted see pready low.
module cxapbasyncbridge_apb_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                   pclkm,
    input  logic                   presetmn,
    input  logic                   pclkenm,
    input  logic [NUM_REQ-1:0]     psels,
    input  logic [NUM_REQ-1:0]     penables,
    input  logic [NUM_REQ-1:0]     pwrites,
    input  logic [32*NUM_REQ-1:0]  paddrs,
    input  logic [32*NUM_REQ-1:0]  pwdatas,
    output logic [NUM_REQ-1:0]     preadys,
    output logic [31:0]            prdatas,
    output logic                   pslverrs,
    output logic                   pselm,
    output logic                   penablem,
    output logic                   pwritem,
    output logic [31:0]            paddrm,
    output logic [31:0]            pwdatam,
    input  logic [31:0]            prdatam,
    input  logic                   pslverrm,
    input  logic                   preadym
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   next_grant;
    logic            any_req;
    logic [GW:0]     rr_sum;
    logic [GW-1:0]   rr_cand;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_write;

    // Requester penable is implied by our own SETUP/ACCESS sequencing, so it is not decoded.
    logic unused_ok;
    assign unused_ok = ^penables;

    // Round-robin search: walk last_grant+1, +2, ... modulo NUM_REQ and take the first request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_grant = last_grant;
        any_req    = 1'b0;
        rr_sum     = '0;
        rr_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, last_grant} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(NUM_REQ))
                rr_sum = rr_sum - (GW+1)'(NUM_REQ);
            rr_cand = rr_sum[GW-1:0];
            if (!any_req && psels[rr_cand]) begin
                any_req    = 1'b1;
                next_grant = rr_cand;
            end
        end
    end

    // Payload of the requester about to be granted.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (next_grant == GW'(i)) begin
                sel_addr  = paddrs[32*i +: 32];
                sel_wdata = pwdatas[32*i +: 32];
                sel_write = pwrites[i];
            end
        end
    end

    // Only the granted requester sees its pready, and only on an enabled completing cycle.
    always_comb begin
        preadys = '0;
        for (int i = 0; i < NUM_REQ; i++)
            preadys[i] = pclkenm & (state == ACCESS) & preadym & (grant == GW'(i));
    end

    assign prdatas  = prdatam;
    assign pslverrs = pslverrm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclkm or negedge presetmn) begin
        if (!presetmn) begin
            state      <= IDLE;
            pselm      <= 1'b0;
            penablem   <= 1'b0;
            pwritem    <= 1'b0;
            paddrm     <= '0;
            pwdatam    <= '0;
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else if (pclkenm) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        paddrm     <= sel_addr;
                        pwdatam    <= sel_wdata;
                        pwritem    <= sel_write;
                        pselm      <= 1'b1;
                        penablem   <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    pselm    <= 1'b1;
                    penablem <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (preadym) begin
                        pselm    <= 1'b0;
                        penablem <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    pselm    <= 1'b0;
                    penablem <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
